// File: rtl/sqrt_datapath.sv
// Iterative restoring integer square root: one root bit per clock after start,
// result captured into held output registers on stop.
//
// state | meaning
// IDLE  | no operand loaded since reset
// RUN   | iterating, one root bit per clock
// DONE  | root/rem complete and frozen until next start
module sqrt_datapath #(
  parameter int NBITSIN = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NBITSIN-1:0]   datain,
  output logic [NBITSIN/2-1:0] sqrtout,
  output logic [NBITSIN/2:0]   remout,
  output logic                 valid,
  output logic                 error
);

  localparam int NH = NBITSIN / 2;
  localparam int RW = NH + 2;
  localparam int CW = $clog2(NH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [NBITSIN-1:0] opnd;
  logic [NH-1:0]      root;
  logic [RW-1:0]      rem;
  logic [CW-1:0]      cnt;
  logic [RW+1:0]      r2;
  logic [RW+1:0]      trial;
  logic [RW-1:0]      diff;
  logic               fits;

  // Compare at full r2 width; when it fits, the true difference is < 2^RW,
  // so the low RW bits of the subtraction are exact.
  always_comb begin
    r2    = {rem, opnd[NBITSIN-1 -: 2]};
    trial = {2'b00, root, 2'b01};
    fits  = (r2 >= trial);
    diff  = r2[RW-1:0] - trial[RW-1:0];
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else if (state == RUN && cnt == CW'(NH - 1)) begin
      state_nxt = DONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opnd <= '0;
      root <= '0;
      rem  <= '0;
      cnt  <= '0;
    end else if (start) begin
      opnd <= datain;
      root <= '0;
      rem  <= '0;
      cnt  <= '0;
    end else if (state == RUN) begin
      opnd <= opnd << 2;
      cnt  <= cnt + 1'b1;
      if (fits) begin
        rem  <= diff;
        root <= {root[NH-2:0], 1'b1};
      end else begin
        rem  <= r2[RW-1:0];
        root <= {root[NH-2:0], 1'b0};
      end
    end
  end

  // stop acts on the pre-start state, so start+stop latches/flags before reloading
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sqrtout <= '0;
      remout  <= '0;
      valid   <= 1'b0;
      error   <= 1'b0;
    end else begin
      valid <= stop && (state == DONE);
      error <= stop && (state != DONE);
      if (stop && state == DONE) begin
        sqrtout <= root;
        remout  <= rem[NH:0];
      end
    end
  end

endmodule

// File: tb/tb_sqrt_datapath.sv
// Directed bench for sqrt_datapath: arithmetic reference model checked every
// cycle, plus literal expectations at the key points.
module tb_sqrt_datapath;
  localparam int N  = 32;
  localparam int NH = N / 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic [N-1:0]  datain;
  logic [NH-1:0] sqrtout;
  logic [NH:0]   remout;
  logic          valid;
  logic          error;

  int errors = 0;
  int checks = 0;

  sqrt_datapath #(.NBITSIN(N)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .datain (datain),
    .sqrtout(sqrtout),
    .remout (remout),
    .valid  (valid),
    .error  (error)
  );

  always #5 clock = ~clock;

  function automatic longint isqrt(input longint x);
    longint lo = 0;
    longint hi = 65536;
    longint mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operand is ready NH clocks after the start edge.
  longint        m_op  = 0;
  int            m_age = -1;
  longint        m_s;
  logic [NH-1:0] exp_s = '0;
  logic [NH:0]   exp_r = '0;
  logic          exp_v = 1'b0;
  logic          exp_e = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_s = '0; exp_r = '0; exp_v = 1'b0; exp_e = 1'b0;
      m_age = -1;
    end else begin
      exp_v = stop && (m_age >= NH);
      exp_e = stop && !(m_age >= NH);
      if (exp_v) begin
        m_s   = isqrt(m_op);
        exp_s = NH'(m_s);
        exp_r = (NH + 1)'(m_op - m_s * m_s);
      end
      if (start) begin
        m_op  = longint'(datain);
        m_age = 0;
      end else if (m_age >= 0 && m_age < NH) begin
        m_age++;
      end
    end
  end

  always @(negedge clock) begin
    chk("sqrtout", 64'(sqrtout), 64'(exp_s));
    chk("remout",  64'(remout),  64'(exp_r));
    chk("valid",   64'(valid),   64'(exp_v));
    chk("error",   64'(error),   64'(exp_e));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_start(input logic [N-1:0] d);
    datain = d; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic lit(input string name, input longint s, input longint r, input logic v, input logic e);
    chk({name, ".sqrtout"}, 64'(sqrtout), 64'(s));
    chk({name, ".remout"},  64'(remout),  64'(r));
    chk({name, ".valid"},   64'(valid),   64'(v));
    chk({name, ".error"},   64'(error),   64'(e));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; datain = '0;
    #1 reset = 1'b0;
    chk("isqrt17", 64'(isqrt(17)), 64'd4);
    chk("isqrtmax", 64'(isqrt(64'hFFFF_FFFF)), 64'hFFFF);
    @(posedge clock); #2;
    reset = 1'b1;
    tick(2);
    lit("reset", 0, 0, 1'b0, 1'b0);

    do_stop();
    lit("stop_idle", 0, 0, 1'b0, 1'b1);
    tick(1);
    lit("stop_idle_pulse", 0, 0, 1'b0, 1'b0);

    do_start(32'd1000000); tick(20); do_stop();
    lit("sq1e6", 1000, 0, 1'b1, 1'b0);
    tick(1);
    lit("sq1e6_pulse", 1000, 0, 1'b0, 1'b0);

    do_start(32'd17); tick(20); do_stop();
    lit("sq17", 4, 1, 1'b1, 1'b0);

    do_start(32'd0); tick(20); do_stop();
    lit("sq0", 0, 0, 1'b1, 1'b0);

    do_start(32'hFFFF_FFFF); tick(20); do_stop();
    lit("sqmax", 16'hFFFF, 17'h1FFFE, 1'b1, 1'b0);
    do_stop();
    lit("restop", 16'hFFFF, 17'h1FFFE, 1'b1, 1'b0);

    do_start(32'd99); tick(5); do_stop();
    lit("early", 16'hFFFF, 17'h1FFFE, 1'b0, 1'b1);
    do_start(32'd99); tick(16); do_stop();
    lit("sq99", 9, 18, 1'b1, 1'b0);

    do_start(32'd50); tick(15); do_stop();
    lit("edge15", 9, 18, 1'b0, 1'b1);
    do_stop();
    lit("edge16", 7, 1, 1'b1, 1'b0);

    datain = 32'd200; start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    lit("start_stop", 7, 1, 1'b1, 1'b0);
    tick(16); do_stop();
    lit("sq200", 14, 4, 1'b1, 1'b0);

    do_start(32'd12345); tick(5);
    reset = 1'b0;
    #1;
    lit("rst_mid", 0, 0, 1'b0, 1'b0);
    @(posedge clock); #2;
    reset = 1'b1;
    tick(1);
    do_stop();
    lit("rst_stop", 0, 0, 1'b0, 1'b1);
    do_start(32'd144); tick(16); do_stop();
    lit("sq144", 12, 0, 1'b1, 1'b0);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
